boundary_scan_chain: RTL

Parametrised boundary-scan register: WIDTH boundary cells chained serially, plus an on-block sequencer that runs a complete capture → shift → update scan from a single start pulse. It sits between the chip pins and the core logic, one instance per pin group. It supersedes hand-wired per-pin cells by adding:
- generic width;
- an automatic shift counter;
- busy/done handshake;
- optional bypass path.

---
 rtl/bsc_pkg.sv | 17 +
 rtl/bsc_cell.sv | 42 ++++
 rtl/boundary_scan_chain.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bsc_pkg.sv
// Shared types and helpers for the boundary-scan chain.
// State encoding and the shift-counter width helper.
package bsc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        UPDATE  = 2'd3
    } bsc_state_t;

    // Counter must hold 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bsc_cell.sv
// One boundary cell: capture/shift flop, update flop, output mux.
// Capture has priority over shift; the two are never enabled together.
module bsc_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_cap_en,
    input  logic i_shift_en,
    input  logic i_upd_en,
    input  logic i_test_mode,
    input  logic i_norm_in,
    input  logic i_shift_in,
    output logic o_cap,
    output logic o_norm_out
);

    logic r_cap;
    logic r_upd;

    // Capture from the normal path or shift from the neighbouring cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= 1'b0;
        end else if (i_cap_en) begin
            r_cap <= i_norm_in;
        end else if (i_shift_en) begin
            r_cap <= i_shift_in;
        end
    end

    // Transfer the shifted value to the pin-facing register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd <= 1'b0;
        end else if (i_upd_en) begin
            r_upd <= r_cap;
        end
    end

    assign o_cap      = r_cap;
    assign o_norm_out = i_test_mode ? r_upd : i_norm_in;

endmodule

// File: rtl/boundary_scan_chain.sv
// WIDTH-cell boundary-scan chain with capture/shift/update sequencer.
// Define BSC_BYPASS_EN to add the bypass_sel port and 1-bit bypass path.
module boundary_scan_chain
    import bsc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef BSC_BYPASS_EN
    input  logic             bypass_sel,
`endif
    input  logic             test_mode,
    input  logic             tdi,
    input  logic [WIDTH-1:0] norm_in,
    output logic             tdo,
    output logic [WIDTH-1:0] norm_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    bsc_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [WIDTH-1:0] w_cap;
    logic             w_byp_mode;
    logic             w_cap_en;
    logic             w_shift_en;
    logic             w_upd_en;

`ifdef BSC_BYPASS_EN
    logic r_byp_mode;
    logic r_byp;

    assign w_byp_mode = r_byp_mode;
    assign tdo        = r_byp_mode ? r_byp : w_cap[0];

    // Bypass mode flag and the single bypass flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_mode <= 1'b0;
            r_byp      <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_byp_mode <= bypass_sel;
            end
            if (r_byp_mode && r_state == CAPTURE) begin
                r_byp <= 1'b0;
            end else if (r_byp_mode && r_state == SHIFT) begin
                r_byp <= tdi;
            end
        end
    end
`else
    assign w_byp_mode = 1'b0;
    assign tdo        = w_cap[0];
`endif

    assign w_cap_en   = (r_state == CAPTURE) && !w_byp_mode;
    assign w_shift_en = (r_state == SHIFT) && !w_byp_mode;
    assign w_upd_en   = (r_state == UPDATE);

    // Scan sequencer: start -> capture -> WIDTH shifts -> update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_byp_mode) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic w_sin;
            if (gi == WIDTH - 1) begin : g_top
                assign w_sin = tdi;
            end else begin : g_mid
                assign w_sin = w_cap[gi+1];
            end
            bsc_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .i_cap_en   (w_cap_en),
                .i_shift_en (w_shift_en),
                .i_upd_en   (w_upd_en),
                .i_test_mode(test_mode),
                .i_norm_in  (norm_in[gi]),
                .i_shift_in (w_sin),
                .o_cap      (w_cap[gi]),
                .o_norm_out (norm_out[gi])
            );
        end
    endgenerate

endmodule
